xif_offload_initiator: RTL and testbench

- Core-side initiator of the eXtension interface (XIF): takes one offloadable instruction at a time from the execute stage and drives the issue, commit and result channels towards a coprocessor such as the AES unit.
- Sequences issue handshake -> commit/kill -> result collection -> register-file writeback.
- Single outstanding instruction; reports illegal (not accepted), ID mismatch and result timeout to the controller.

---
 rtl/xif_offload_initiator.sv | 193 +++++++++++++++++++
 tb/tb_xif_offload_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_offload_initiator.sv
// rtl/xif_offload_initiator.sv - XIF core-side offload initiator
// Carries one instruction at a time through issue, commit/kill, result and register-file writeback.

module xif_offload_initiator #(
   parameter int X_NUM_RS       = 2,
   parameter int X_ID_WIDTH     = 4,
   parameter int X_RFR_WIDTH    = 32,
   parameter int X_RFW_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            instr_valid_i,
   output logic                            instr_ready_o,
   input  logic [31:0]                     instr_i,
   input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_i,
   input  logic [X_NUM_RS-1:0]             rs_valid_i,
   input  logic                            flush_i,
   output logic                            x_issue_valid_o,
   input  logic                            x_issue_ready_i,
   output logic [31:0]                     x_issue_instr_o,
   output logic [X_ID_WIDTH-1:0]           x_issue_id_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0] x_issue_rs_o,
   output logic [X_NUM_RS-1:0]             x_issue_rs_valid_o,
   input  logic                            x_issue_accept_i,
   input  logic                            x_issue_writeback_i,
   output logic                            x_commit_valid_o,
   output logic [X_ID_WIDTH-1:0]           x_commit_id_o,
   output logic                            x_commit_kill_o,
   input  logic                            x_result_valid_i,
   output logic                            x_result_ready_o,
   input  logic [X_ID_WIDTH-1:0]           x_result_id_i,
   input  logic [X_RFW_WIDTH-1:0]          x_result_data_i,
   input  logic [4:0]                      x_result_rd_i,
   input  logic                            x_result_we_i,
   output logic                            rf_we_o,
   output logic [4:0]                      rf_waddr_o,
   output logic [X_RFW_WIDTH-1:0]          rf_wdata_o,
   output logic                            busy_o,
   output logic                            illegal_o,
   output logic                            id_mismatch_o,
   output logic                            timeout_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, WAIT_RES} state_t;

   state_t                          state;
   logic [X_ID_WIDTH-1:0]           next_id;
   logic [X_ID_WIDTH-1:0]           out_id;
   logic [TW-1:0]                   timer;
   logic                            kill_pending;
   logic                            accepted;
   logic                            writeback;
   logic [31:0]                     instr_reg;
   logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_reg;
   logic [X_NUM_RS-1:0]             rs_valid_reg;
   logic                            instr_ready;
   logic                            issue_valid;
   logic                            commit_valid;
   logic                            result_ready;
   logic                            busy;
   logic                            rf_we;
   logic [4:0]                      rf_waddr;
   logic [X_RFW_WIDTH-1:0]          rf_wdata;
   logic                            illegal;
   logic                            id_mismatch;
   logic                            timeout;

   logic kill;
   logic result_hs;
   logic id_match;
   logic timer_done;

   // A flush arriving in the commit cycle itself still kills the instruction.
   assign kill       = kill_pending | flush_i | !accepted;
   assign result_hs  = result_ready & x_result_valid_i;
   assign id_match   = (x_result_id_i == out_id);
   assign timer_done = (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         next_id      <= '0;
         out_id       <= '0;
         timer        <= '0;
         kill_pending <= 1'b0;
         accepted     <= 1'b0;
         writeback    <= 1'b0;
         instr_reg    <= '0;
         rs_reg       <= '0;
         rs_valid_reg <= '0;
         instr_ready  <= 1'b1;
         issue_valid  <= 1'b0;
         commit_valid <= 1'b0;
         result_ready <= 1'b0;
         busy         <= 1'b0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         illegal      <= 1'b0;
         id_mismatch  <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         rf_we       <= 1'b0;
         illegal     <= 1'b0;
         id_mismatch <= 1'b0;
         timeout     <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid_i) begin
                  instr_reg    <= instr_i;
                  rs_reg       <= rs_i;
                  rs_valid_reg <= rs_valid_i;
                  instr_ready  <= 1'b0;
                  issue_valid  <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               if (flush_i) kill_pending <= 1'b1;
               if (x_issue_ready_i) begin
                  accepted     <= x_issue_accept_i;
                  writeback    <= x_issue_writeback_i;
                  out_id       <= next_id;
                  next_id      <= next_id + X_ID_WIDTH'(1);
                  issue_valid  <= 1'b0;
                  commit_valid <= 1'b1;
                  state        <= COMMIT;
               end
            end
            COMMIT: begin
               commit_valid <= 1'b0;
               kill_pending <= 1'b0;
               if (kill || !writeback) begin
                  illegal     <= !accepted;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  timer        <= '0;
                  result_ready <= 1'b1;
                  state        <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               timer <= timer + TW'(1);
               // A matching result wins over a timeout expiring in the same cycle.
               if (result_hs && id_match) begin
                  rf_we        <= x_result_we_i & (x_result_rd_i != 5'd0);
                  rf_waddr     <= x_result_rd_i;
                  rf_wdata     <= x_result_data_i;
                  result_ready <= 1'b0;
                  instr_ready  <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  id_mismatch <= result_hs;
                  if (timer_done) begin
                     timeout      <= 1'b1;
                     result_ready <= 1'b0;
                     instr_ready  <= 1'b1;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_ready_o      = instr_ready;
   assign x_issue_valid_o    = issue_valid;
   assign x_issue_instr_o    = instr_reg;
   assign x_issue_id_o       = next_id;
   assign x_issue_rs_o       = rs_reg;
   assign x_issue_rs_valid_o = rs_valid_reg;
   assign x_commit_valid_o   = commit_valid;
   assign x_commit_id_o      = out_id;
   assign x_commit_kill_o    = commit_valid & kill;
   assign x_result_ready_o   = result_ready;
   assign rf_we_o            = rf_we;
   assign rf_waddr_o         = rf_waddr;
   assign rf_wdata_o         = rf_wdata;
   assign busy_o             = busy;
   assign illegal_o          = illegal;
   assign id_mismatch_o      = id_mismatch;
   assign timeout_o          = timeout;

endmodule

// File: tb/tb_xif_offload_initiator.sv
// tb/tb_xif_offload_initiator.sv - self-checking bench for xif_offload_initiator
// Transaction-level expectations are checked against the DUT on every falling edge.

module tb_xif_offload_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid_i, instr_ready_o;
   logic [31:0] instr_i;
   logic [63:0] rs_i;
   logic [1:0]  rs_valid_i;
   logic        flush_i;
   logic        x_issue_valid_o, x_issue_ready_i;
   logic [31:0] x_issue_instr_o;
   logic [3:0]  x_issue_id_o;
   logic [63:0] x_issue_rs_o;
   logic [1:0]  x_issue_rs_valid_o;
   logic        x_issue_accept_i, x_issue_writeback_i;
   logic        x_commit_valid_o;
   logic [3:0]  x_commit_id_o;
   logic        x_commit_kill_o;
   logic        x_result_valid_i, x_result_ready_o;
   logic [3:0]  x_result_id_i;
   logic [31:0] x_result_data_i;
   logic [4:0]  x_result_rd_i;
   logic        x_result_we_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        busy_o, illegal_o, id_mismatch_o, timeout_o;

   xif_offload_initiator #(
      .X_NUM_RS(2), .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
      .rs_i(rs_i), .rs_valid_i(rs_valid_i), .flush_i(flush_i),
      .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
      .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
      .x_issue_rs_o(x_issue_rs_o), .x_issue_rs_valid_o(x_issue_rs_valid_o),
      .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
      .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
      .x_commit_kill_o(x_commit_kill_o),
      .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
      .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
      .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .busy_o(busy_o), .illegal_o(illegal_o), .id_mismatch_o(id_mismatch_o),
      .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   logic        e_ready, e_iv, e_cv, e_kill, e_rr, e_busy, e_ill, e_mis, e_to, e_we;
   logic [31:0] e_instr, e_wdata;
   logic [63:0] e_rs;
   logic [1:0]  e_rsv;
   logic [3:0]  e_id, e_cid;
   logic [4:0]  e_waddr;
   logic        wb_known;
   int          model_id;
   logic [3:0]  out_id;
   int          wcount;
   logic        waiting, done;
   logic [3:0]  obs_cid;
   logic        obs_kill, obs_ill;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr_ready", 64'(instr_ready_o), 64'(e_ready));
         chk("issue_valid", 64'(x_issue_valid_o), 64'(e_iv));
         chk("commit_valid", 64'(x_commit_valid_o), 64'(e_cv));
         chk("result_ready", 64'(x_result_ready_o), 64'(e_rr));
         chk("busy", 64'(busy_o), 64'(e_busy));
         chk("illegal", 64'(illegal_o), 64'(e_ill));
         chk("id_mismatch", 64'(id_mismatch_o), 64'(e_mis));
         chk("timeout", 64'(timeout_o), 64'(e_to));
         chk("rf_we", 64'(rf_we_o), 64'(e_we));
         if (e_iv) begin
            chk("issue_instr", 64'(x_issue_instr_o), 64'(e_instr));
            chk("issue_id", 64'(x_issue_id_o), 64'(e_id));
            chk("issue_rs", x_issue_rs_o, e_rs);
            chk("issue_rs_valid", 64'(x_issue_rs_valid_o), 64'(e_rsv));
         end
         if (e_cv) begin
            chk("commit_id", 64'(x_commit_id_o), 64'(e_cid));
            chk("commit_kill", 64'(x_commit_kill_o), 64'(e_kill));
         end
         if (wb_known) begin
            chk("rf_waddr", 64'(rf_waddr_o), 64'(e_waddr));
            chk("rf_wdata", 64'(rf_wdata_o), 64'(e_wdata));
         end
      end
   end

   task automatic idle_exp();
      e_ready = 1'b1; e_busy = 1'b0; e_rr = 1'b0; e_iv = 1'b0; e_cv = 1'b0;
   endtask

   task automatic reset_exp();
      idle_exp();
      e_kill = 1'b0; e_ill = 1'b0; e_mis = 1'b0; e_to = 1'b0; e_we = 1'b0;
      e_waddr = '0; e_wdata = '0; wb_known = 1'b1; model_id = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      e_ill = 1'b0; e_mis = 1'b0; e_to = 1'b0; e_we = 1'b0;
   endtask

   // Present one instruction from IDLE and follow it through issue and commit.
   task automatic offload(input logic [31:0] ins, input logic [63:0] rs, input logic [1:0] rsv,
                          input int stall, input int flush_cyc, input logic flush_cm,
                          input logic acc, input logic wb, output logic wait_res_entered);
      logic kp;
      instr_valid_i = 1'b1; instr_i = ins; rs_i = rs; rs_valid_i = rsv;
      step();
      instr_valid_i = 1'b0; instr_i = $urandom; rs_i = {$urandom, $urandom}; rs_valid_i = ~rsv;
      e_ready = 1'b0; e_busy = 1'b1; e_iv = 1'b1;
      e_instr = ins; e_rs = rs; e_rsv = rsv; e_id = 4'(model_id);
      kp = 1'b0;
      for (int c = 0; c <= stall; c++) begin
         x_issue_ready_i     = (c == stall);
         x_issue_accept_i    = (c == stall) ? acc : ~acc;
         x_issue_writeback_i = (c == stall) ? wb : ~wb;
         flush_i             = (c == flush_cyc);
         if (flush_i) kp = 1'b1;
         step();
      end
      x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;
      flush_i = flush_cm;
      e_iv = 1'b0; e_cv = 1'b1; e_cid = 4'(model_id); e_kill = kp | flush_cm | !acc;
      out_id = 4'(model_id);
      model_id = (model_id + 1) % 16;
      #1;
      obs_cid = x_commit_id_o; obs_kill = x_commit_kill_o;
      step();
      flush_i = 1'b0;
      e_cv = 1'b0;
      if (!acc || kp || flush_cm || !wb) begin
         e_ill = !acc;
         idle_exp();
         wait_res_entered = 1'b0;
      end else begin
         e_rr = 1'b1;
         wcount = 0;
         wait_res_entered = 1'b1;
      end
      obs_ill = illegal_o;
   endtask

   // Offer one result after `delay` idle cycles; stops early on timeout.
   task automatic wait_res(input int delay, input logic [3:0] rid, input logic [31:0] data,
                           input logic [4:0] rd, input logic we, output logic finished);
      logic match;
      finished = 1'b0;
      for (int c = 0; c <= delay; c++) begin
         x_result_valid_i = (c == delay);
         x_result_id_i    = (c == delay) ? rid : 4'($urandom);
         x_result_data_i  = (c == delay) ? data : $urandom;
         x_result_rd_i    = (c == delay) ? rd : 5'($urandom);
         x_result_we_i    = (c == delay) ? we : 1'($urandom);
         match = (c == delay) && (rid == out_id);
         step();
         wcount++;
         x_result_valid_i = 1'b0;
         if (match) begin
            e_we = we && (rd != 5'd0); e_waddr = rd; e_wdata = data;
            idle_exp();
            finished = 1'b1;
            return;
         end
         if (c == delay) e_mis = 1'b1;
         if (wcount == 8) begin
            e_to = 1'b1;
            idle_exp();
            finished = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      instr_valid_i = 0; instr_i = 0; rs_i = 0; rs_valid_i = 0; flush_i = 0;
      x_issue_ready_i = 0; x_issue_accept_i = 0; x_issue_writeback_i = 0;
      x_result_valid_i = 0; x_result_id_i = 0; x_result_data_i = 0; x_result_rd_i = 0;
      x_result_we_i = 0;
      out_id = 0; wcount = 0;
      reset_exp();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_issue_instr", 64'(x_issue_instr_o), 64'h0);
      chk("reset_issue_id", 64'(x_issue_id_o), 64'h0);
      chk("reset_issue_rs", x_issue_rs_o, 64'h0);
      chk("reset_commit_id", 64'(x_commit_id_o), 64'h0);
      rst_n = 1'b1;
      step();

      // basic AES offload
      offload(32'h2A0000B3, {32'h22222222, 32'h11111111}, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      chk("basic_commit_id", 64'(obs_cid), 64'h0);
      chk("basic_commit_kill", 64'(obs_kill), 64'h0);
      chk("basic_wait", 64'(waiting), 64'h1);
      wait_res(0, 4'd0, 32'hDEADBEEF, 5'd1, 1'b1, done);
      chk("basic_rf_we", 64'(rf_we_o), 64'h1);
      chk("basic_rf_waddr", 64'(rf_waddr_o), 64'h1);
      chk("basic_rf_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
      step();

      // not accepted
      offload(32'h0000502B, {32'hA5A5A5A5, 32'h5A5A5A5A}, 2'b10, 0, -1, 1'b0, 1'b0, 1'b1, waiting);
      chk("illegal_commit_id", 64'(obs_cid), 64'h1);
      chk("illegal_commit_kill", 64'(obs_kill), 64'h1);
      chk("illegal_pulse", 64'(obs_ill), 64'h1);
      step();

      // issue backpressure with flush during stall
      offload(32'h1234567B, {32'hCAFEBABE, 32'h0BADF00D}, 2'b01, 5, 2, 1'b0, 1'b1, 1'b1, waiting);
      chk("stall_commit_id", 64'(obs_cid), 64'h2);
      chk("stall_commit_kill", 64'(obs_kill), 64'h1);
      step();

      // accepted without writeback, then flush in the commit cycle
      offload(32'h0000000B, 64'h1, 2'b00, 1, -1, 1'b0, 1'b1, 1'b0, waiting);
      chk("nowb_commit_kill", 64'(obs_kill), 64'h0);
      step();
      offload(32'h0000100B, 64'h2, 2'b11, 0, -1, 1'b1, 1'b1, 1'b1, waiting);
      chk("cflush_commit_kill", 64'(obs_kill), 64'h1);
      step();

      // rd=0 with we=1, then we=0 with rd!=0
      offload(32'h0000200B, 64'h3, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      wait_res(1, out_id, 32'hCAFEF00D, 5'd0, 1'b1, done);
      chk("rd0_rf_we", 64'(rf_we_o), 64'h0);
      step();
      offload(32'h0000300B, 64'h4, 2'b11, 2, -1, 1'b0, 1'b1, 1'b1, waiting);
      wait_res(0, out_id, 32'h00C0FFEE, 5'd9, 1'b0, done);
      chk("we0_rf_we", 64'(rf_we_o), 64'h0);
      step();

      // ID wrap: sixteen quick offloads, then advance to ID 5
      for (int i = 0; i < 16; i++) begin
         offload(32'h0000400B + 32'(i), 64'(i), 2'b01, 0, -1, 1'b0, 1'b1, 1'b0, waiting);
         step();
      end
      while (model_id != 5) begin
         offload(32'h0000500B, 64'h5, 2'b10, 0, -1, 1'b0, 1'b1, 1'b0, waiting);
         step();
      end

      // mismatching result then matching result
      offload(32'h0000600B, {32'h01020304, 32'h05060708}, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      chk("mis_commit_id", 64'(obs_cid), 64'h5);
      wait_res(1, 4'd3, 32'hBAD0BAD0, 5'd4, 1'b1, done);
      chk("mis_pulse", 64'(id_mismatch_o), 64'h1);
      chk("mis_still_busy", 64'(busy_o), 64'h1);
      wait_res(2, 4'd5, 32'h12345678, 5'd7, 1'b1, done);
      chk("mis_then_rf_waddr", 64'(rf_waddr_o), 64'h7);
      step();

      // timeout with no result
      offload(32'h0000700B, 64'h6, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      wait_res(20, 4'd0, 32'h0, 5'd0, 1'b0, done);
      chk("timeout_pulse", 64'(timeout_o), 64'h1);
      chk("timeout_busy", 64'(busy_o), 64'h0);
      step();

      // result in the last timer cycle beats the timeout
      offload(32'h0000800B, 64'h7, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      wait_res(7, out_id, 32'h55AA55AA, 5'd31, 1'b1, done);
      chk("late_rf_we", 64'(rf_we_o), 64'h1);
      chk("late_no_timeout", 64'(timeout_o), 64'h0);
      step();

      // asynchronous reset while waiting for a result
      offload(32'h0000900B, 64'h8, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("arst_result_ready", 64'(x_result_ready_o), 64'h0);
      chk("arst_busy", 64'(busy_o), 64'h0);
      chk("arst_rf_waddr", 64'(rf_waddr_o), 64'h0);
      chk("arst_issue_id", 64'(x_issue_id_o), 64'h0);
      reset_exp();
      step();
      rst_n = 1'b1;
      step();
      offload(32'h2A0000B3, {32'h33333333, 32'h44444444}, 2'b11, 0, -1, 1'b0, 1'b1, 1'b1, waiting);
      chk("post_reset_commit_id", 64'(obs_cid), 64'h0);
      wait_res(0, 4'd0, 32'h0F0F0F0F, 5'd2, 1'b1, done);
      step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
